discretizador_multinivel: RTL

Parametrised successor to the fixed 3-digit, 4-category BCD discretiser, for the sensor-readout path. It takes an N-digit BCD reading on a `load` request and converts it serially to binary, one digit per cycle. It then classifies the value against LEVELS-1 runtime-programmable thresholds, applies downward hysteresis and a persistence filter, and publishes a registered category with a one-cycle `valid` pulse.

---
 rtl/discretizador_pkg.sv | 19 +
 rtl/bcd_serial_conv.sv | 53 +++++
 rtl/discretizador_multinivel.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/discretizador_pkg.sv
// Shared types and constants for the multi-level BCD discretiser.
package discretizador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        CLASS = 2'd2
    } estado_t;

    localparam int unsigned BCD_MAX   = 9;
    localparam int unsigned LIM_DEF_W = 16;
    localparam logic [3*LIM_DEF_W-1:0] LIM_DEF = {16'd18, 16'd12, 16'd6};

    // True when a nibble is not a legal BCD digit.
    function automatic logic bcd_invalido(input logic [3:0] d);
        return d > 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_conv.sv
// Serial BCD-to-binary converter: one digit per step, most-significant first.
module bcd_serial_conv
    import discretizador_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned VAL_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_step,
    input  logic [4*DIGITS-1:0]   i_bits,
    output logic [VAL_W-1:0]      o_acc,
    output logic                  o_invalid,
    output logic                  o_done_c
);

    localparam int unsigned IN_W  = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DIGITS + 1);

    logic [IN_W-1:0]  r_shift;
    logic [VAL_W-1:0] r_acc;
    logic             r_invalid;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_digit;

    assign w_digit   = r_shift[IN_W-1 -: 4];
    assign o_acc     = r_acc;
    assign o_invalid = r_invalid;
    // High on the step that consumes the last digit.
    assign o_done_c  = i_step && (r_cnt == CNT_W'(DIGITS - 1));

    // Capture on start, then shift one nibble and accumulate acc*10+digit per step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_acc     <= '0;
            r_invalid <= 1'b0;
            r_cnt     <= '0;
        end else if (i_start) begin
            r_shift   <= i_bits;
            r_acc     <= '0;
            r_invalid <= 1'b0;
            r_cnt     <= '0;
        end else if (i_step) begin
            r_shift   <= r_shift << 4;
            r_acc     <= VAL_W'((r_acc << 3) + (r_acc << 1)) + VAL_W'(w_digit);
            r_invalid <= r_invalid | bcd_invalido(w_digit);
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/discretizador_multinivel.sv
// Multi-level BCD discretiser: serial conversion, threshold classification,
// downward hysteresis and persistence filtering of the published category.
module discretizador_multinivel
    import discretizador_pkg::*;
#(
    parameter int unsigned DIGITS  = 3,
    parameter int unsigned LEVELS  = 4,
    parameter int unsigned OUT_W   = $clog2(LEVELS),
    parameter int unsigned VAL_W   = 16,
    parameter int unsigned HYST    = 1,
    parameter int unsigned PERSIST = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [4*DIGITS-1:0]         bits_in,
    input  logic [(LEVELS-1)*VAL_W-1:0] limiares,
    output logic                        busy,
    output logic                        valid,
    output logic [OUT_W-1:0]            saida,
    output logic [VAL_W-1:0]            valor,
    output logic                        erro
);

    localparam int unsigned PCNT_W = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);

    estado_t           r_state;
    logic              r_busy;
    logic              r_valid;
    logic [OUT_W-1:0]  r_saida;
    logic [VAL_W-1:0]  r_valor;
    logic              r_erro;
    logic [OUT_W-1:0]  r_pend;
    logic [PCNT_W-1:0] r_cnt;

    logic              w_start;
    logic              w_step;
    logic [VAL_W-1:0]  w_acc;
    logic              w_inv;
    logic              w_done_c;
    logic [OUT_W-1:0]  w_raw;
    logic [VAL_W-1:0]  w_lim_baixo;
    logic [VAL_W-1:0]  w_lim_hist;
    logic [OUT_W-1:0]  w_cand;
    logic [OUT_W-1:0]  w_saida_nx;
    logic [OUT_W-1:0]  w_pend_nx;
    logic [PCNT_W-1:0] w_cnt_nx;
    logic [PCNT_W-1:0] w_cnt_inc;

    // CLASS is the final cycle of a request and doubles as an acceptance slot,
    // giving one reading every DIGITS+1 cycles.
    assign w_start = load && ((r_state == IDLE) || (r_state == CLASS));
    assign w_step  = (r_state == CONV);

    bcd_serial_conv #(
        .DIGITS (DIGITS),
        .VAL_W  (VAL_W)
    ) u_conv (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_step    (w_step),
        .i_bits    (bits_in),
        .o_acc     (w_acc),
        .o_invalid (w_inv),
        .o_done_c  (w_done_c)
    );

    // Raw category: number of thresholds strictly below the value.
    always_comb begin
        w_raw = '0;
        for (int k = 0; k < int'(LEVELS) - 1; k++) begin
            if (w_acc > limiares[k*VAL_W +: VAL_W])
                w_raw = w_raw + OUT_W'(1);
        end
    end

    // Downward hysteresis: stay put while above T[saida-1] minus the margin.
    always_comb begin
        w_lim_baixo = '0;
        for (int k = 0; k < int'(LEVELS) - 1; k++) begin
            if (OUT_W'(k + 1) == r_saida)
                w_lim_baixo = limiares[k*VAL_W +: VAL_W];
        end
        w_lim_hist = (w_lim_baixo > VAL_W'(HYST)) ? (w_lim_baixo - VAL_W'(HYST)) : '0;
        w_cand     = ((w_raw < r_saida) && (w_acc > w_lim_hist)) ? r_saida : w_raw;
    end

    // Persistence filter: candidate must repeat PERSIST times before it is published.
    always_comb begin
        w_saida_nx = r_saida;
        w_pend_nx  = r_pend;
        w_cnt_nx   = r_cnt;
        w_cnt_inc  = '0;
        if (w_cand == r_saida) begin
            w_cnt_nx = '0;
        end else begin
            if (w_cand == r_pend) begin
                w_cnt_inc = r_cnt + PCNT_W'(1);
            end else begin
                w_pend_nx = w_cand;
                w_cnt_inc = PCNT_W'(1);
            end
            if (w_cnt_inc >= PCNT_W'(PERSIST)) begin
                w_saida_nx = w_cand;
                w_cnt_nx   = '0;
            end else begin
                w_cnt_nx   = w_cnt_inc;
            end
        end
    end

    // Control FSM and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_saida <= '0;
            r_valor <= '0;
            r_erro  <= 1'b0;
            r_pend  <= '0;
            r_cnt   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_state <= CONV;
                        r_busy  <= 1'b1;
                    end
                end
                CONV: begin
                    if (w_done_c)
                        r_state <= CLASS;
                end
                CLASS: begin
                    r_valid <= 1'b1;
                    r_erro  <= w_inv;
                    r_valor <= w_inv ? '0 : w_acc;
                    if (!w_inv) begin
                        r_saida <= w_saida_nx;
                        r_pend  <= w_pend_nx;
                        r_cnt   <= w_cnt_nx;
                    end
                    if (load) begin
                        r_state <= CONV;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign saida = r_saida;
    assign valor = r_valor;
    assign erro  = r_erro;

endmodule
